// File: rtl/layer_priority_arbiter.sv
// ---------------------------------------------------------------------------
// layer_priority_arbiter
//
// Per-pixel arbiter that picks one of NUM_LAYERS drawing layers (or the
// background) according to a programmable priority order. A new order is
// written into a shadow register through a valid/ready handshake and only
// becomes active at the next start of frame, so a frame is never drawn with
// a mix of two orders.
//
// Optional build macro:
//   LAYER_COLLISION_DETECT_EN - when defined, per-layer overlap flags are
//                               accumulated over each frame and published on
//                               collisionMask at the following startOfFrame.
//                               When undefined, collisionMask is tied to 0.
//
// Ports:
//   clk                 in   pixel clock
//   reset               in   synchronous active-high reset
//   startOfFrame        in   one-cycle pulse at the first pixel of a frame
//   layerDrawingRequest in   per-layer draw request for the current pixel
//   layerRGB            in   per-layer RGB332 colour
//   backGroundRGB       in   background colour
//   cfgValid            in   priority-update request
//   cfgOrder            in   packed layer indices, [1:0] highest priority
//   cfgReady            out  update can be accepted (config FSM idle)
//   cfgError            out  one-cycle pulse on accepted non-permutation
//   pixelRGB            out  selected colour, one cycle after the inputs
//   pixelFromLayer      out  pixelRGB came from a layer
//   pixelLayer          out  winning layer index (0 for background)
//   collisionMask       out  overlap flags of the previous frame
// ---------------------------------------------------------------------------
module layer_priority_arbiter #(
    parameter int unsigned NUM_LAYERS = 4,
    parameter int unsigned RGB_W      = 8
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        startOfFrame,
    input  logic [NUM_LAYERS-1:0]                       layerDrawingRequest,
    input  logic [NUM_LAYERS-1:0][RGB_W-1:0]            layerRGB,
    input  logic [RGB_W-1:0]                            backGroundRGB,
    input  logic                                        cfgValid,
    input  logic [NUM_LAYERS*$clog2(NUM_LAYERS)-1:0]    cfgOrder,
    output logic                                        cfgReady,
    output logic                                        cfgError,
    output logic [RGB_W-1:0]                            pixelRGB,
    output logic                                        pixelFromLayer,
    output logic [$clog2(NUM_LAYERS)-1:0]               pixelLayer,
    output logic [NUM_LAYERS-1:0]                       collisionMask
);

    localparam int unsigned IDX_W   = $clog2(NUM_LAYERS);
    localparam int unsigned ORDER_W = NUM_LAYERS * IDX_W;

    // Slot k holds layer k: layer 0 has the highest priority.
    function automatic logic [ORDER_W-1:0] identity_order();
        logic [ORDER_W-1:0] o;
        o = '0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            o[k*IDX_W +: IDX_W] = IDX_W'(k);
        end
        return o;
    endfunction

    localparam logic [ORDER_W-1:0] IDENTITY = identity_order();

    typedef enum logic [0:0] {StIdle, StPending} cfg_state_e;

    cfg_state_e          r_cfg_state;
    cfg_state_e          w_cfg_state_d;
    logic [ORDER_W-1:0]  r_active;
    logic [ORDER_W-1:0]  w_active_d;
    logic [ORDER_W-1:0]  r_shadow;
    logic [ORDER_W-1:0]  w_shadow_d;
    logic                r_cfg_error;
    logic                w_cfg_error_d;

    logic [NUM_LAYERS-1:0] w_seen;
    logic                  w_is_perm;
    logic [ORDER_W-1:0]    w_order;
    logic                  w_hit;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_slot;

    logic [RGB_W-1:0]      r_pixel_rgb;
    logic                  r_pixel_from_layer;
    logic [IDX_W-1:0]      r_pixel_layer;

    // An order is legal only if every layer index appears exactly once.
    always_comb begin
        w_seen = '0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            w_seen[cfgOrder[k*IDX_W +: IDX_W]] = 1'b1;
        end
        w_is_perm = &w_seen;
    end

    // ------------------------------------------------------------------
    // Config FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cfg_state <= StIdle;
            r_active    <= IDENTITY;
            r_shadow    <= IDENTITY;
            r_cfg_error <= 1'b0;
        end else begin
            r_cfg_state <= w_cfg_state_d;
            r_active    <= w_active_d;
            r_shadow    <= w_shadow_d;
            r_cfg_error <= w_cfg_error_d;
        end
    end

    always_comb begin
        w_cfg_state_d = r_cfg_state;
        w_active_d    = r_active;
        w_shadow_d    = r_shadow;
        w_cfg_error_d = 1'b0;
        case (r_cfg_state)
            StIdle: begin
                // cfgReady is 1 here, so cfgValid alone means accepted.
                if (cfgValid) begin
                    if (w_is_perm) begin
                        w_shadow_d    = cfgOrder;
                        w_cfg_state_d = StPending;
                    end else begin
                        w_cfg_error_d = 1'b1;
                    end
                end
            end
            StPending: begin
                if (startOfFrame) begin
                    w_active_d    = r_shadow;
                    w_cfg_state_d = StIdle;
                end
            end
            default: w_cfg_state_d = StIdle;
        endcase
    end

    assign cfgReady = (r_cfg_state == StIdle);
    assign cfgError = r_cfg_error;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // The pending order already governs the first pixel of the new frame.
    assign w_order = ((r_cfg_state == StPending) && startOfFrame) ? r_shadow : r_active;

    // Walk from lowest to highest priority so the highest active slot wins.
    always_comb begin
        w_hit  = 1'b0;
        w_win  = '0;
        w_slot = '0;
        for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
            w_slot = w_order[(NUM_LAYERS-1-k)*IDX_W +: IDX_W];
            if (layerDrawingRequest[w_slot]) begin
                w_hit = 1'b1;
                w_win = w_slot;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixel_rgb        <= '0;
            r_pixel_from_layer <= 1'b0;
            r_pixel_layer      <= '0;
        end else begin
            r_pixel_rgb        <= w_hit ? layerRGB[w_win] : backGroundRGB;
            r_pixel_from_layer <= w_hit;
            r_pixel_layer      <= w_hit ? w_win : '0;
        end
    end

    assign pixelRGB       = r_pixel_rgb;
    assign pixelFromLayer = r_pixel_from_layer;
    assign pixelLayer     = r_pixel_layer;

    // ------------------------------------------------------------------
    // Collision detection
    // ------------------------------------------------------------------
`ifdef LAYER_COLLISION_DETECT_EN
    logic [NUM_LAYERS-1:0] r_coll_acc;
    logic [NUM_LAYERS-1:0] r_coll_mask;
    logic [NUM_LAYERS-1:0] w_coll_bits;

    // x & (x-1) is non-zero exactly when two or more bits are set.
    assign w_coll_bits = ((layerDrawingRequest & (layerDrawingRequest - 1'b1)) != '0)
                         ? layerDrawingRequest : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coll_acc  <= '0;
            r_coll_mask <= '0;
        end else if (startOfFrame) begin
            r_coll_mask <= r_coll_acc;
            r_coll_acc  <= w_coll_bits;
        end else begin
            r_coll_acc  <= r_coll_acc | w_coll_bits;
        end
    end

    assign collisionMask = r_coll_mask;
`else
    assign collisionMask = '0;
`endif

endmodule

// File: tb/tb_layer_priority_arbiter.sv
module tb_layer_priority_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       startOfFrame;
    logic [3:0] layerDrawingRequest;
    logic [3:0][7:0] layerRGB;
    logic [7:0] backGroundRGB;
    logic       cfgValid;
    logic [7:0] cfgOrder;
    logic       cfgReady;
    logic       cfgError;
    logic [7:0] pixelRGB;
    logic       pixelFromLayer;
    logic [1:0] pixelLayer;
    logic [3:0] collisionMask;

    always #5 clk = ~clk;

    layer_priority_arbiter #(
        .NUM_LAYERS(4),
        .RGB_W     (8)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .startOfFrame       (startOfFrame),
        .layerDrawingRequest(layerDrawingRequest),
        .layerRGB           (layerRGB),
        .backGroundRGB      (backGroundRGB),
        .cfgValid           (cfgValid),
        .cfgOrder           (cfgOrder),
        .cfgReady           (cfgReady),
        .cfgError           (cfgError),
        .pixelRGB           (pixelRGB),
        .pixelFromLayer     (pixelFromLayer),
        .pixelLayer         (pixelLayer),
        .collisionMask      (collisionMask)
    );

    typedef struct {
        logic [7:0] rgb;
        logic       from;
        logic [1:0] layer;
        logic       ready;
        logic       err;
        logic [3:0] cmask;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: priority list as an array of layer numbers,
    // collision tracking as plain per-layer flags.
    int m_active[4];
    int m_shadow[4];
    bit m_pending;
    bit m_acc[4];
    bit m_mask[4];

    function automatic bit is_perm(logic [7:0] o);
        int cnt[4];
        for (int s = 0; s < 4; s++) cnt[s] = 0;
        for (int s = 0; s < 4; s++) cnt[int'(o[2*s +: 2])]++;
        for (int s = 0; s < 4; s++) if (cnt[s] != 1) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_active[s] = s;
            m_shadow[s] = s;
            m_acc[s]    = 1'b0;
            m_mask[s]   = 1'b0;
        end
        m_pending = 1'b0;
    endtask

    // Applies the current inputs to the model, waits for the clock edge and
    // queues what the DUT must show after that edge.
    task automatic step();
        exp_t e;
        int   used[4];
        int   nreq;
        bit   accept;
        e.rgb = 8'h00; e.from = 1'b0; e.layer = 2'd0; e.err = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            accept = cfgValid && !m_pending;
            for (int s = 0; s < 4; s++) used[s] = (m_pending && startOfFrame) ? m_shadow[s] : m_active[s];
            e.rgb = backGroundRGB;
            for (int s = 0; s < 4; s++) begin
                if (!e.from && layerDrawingRequest[used[s]]) begin
                    e.from  = 1'b1;
                    e.layer = 2'(used[s]);
                    e.rgb   = layerRGB[used[s]];
                end
            end
            e.err = accept && !is_perm(cfgOrder);
            if (m_pending && startOfFrame) begin
                for (int s = 0; s < 4; s++) m_active[s] = m_shadow[s];
                m_pending = 1'b0;
            end
            if (accept && is_perm(cfgOrder)) begin
                for (int s = 0; s < 4; s++) m_shadow[s] = int'(cfgOrder[2*s +: 2]);
                m_pending = 1'b1;
            end
            nreq = $countones(layerDrawingRequest);
            if (startOfFrame) begin
                for (int s = 0; s < 4; s++) begin
                    m_mask[s] = m_acc[s];
                    m_acc[s]  = (nreq >= 2) && layerDrawingRequest[s];
                end
            end else begin
                for (int s = 0; s < 4; s++) m_acc[s] = m_acc[s] || ((nreq >= 2) && layerDrawingRequest[s]);
            end
        end
        e.ready = !m_pending;
`ifdef LAYER_COLLISION_DETECT_EN
        for (int s = 0; s < 4; s++) e.cmask[s] = m_mask[s];
`else
        e.cmask = 4'b0000;
`endif
        @(posedge clk);
        sb_q.push_back(e);
        #1;
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle after an edge, so every queued
    // entry is compared at the following falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("pixelRGB",       pixelRGB,              e.rgb);
            chk("pixelFromLayer", {7'd0, pixelFromLayer}, {7'd0, e.from});
            chk("pixelLayer",     {6'd0, pixelLayer},     {6'd0, e.layer});
            chk("cfgReady",       {7'd0, cfgReady},       {7'd0, e.ready});
            chk("cfgError",       {7'd0, cfgError},       {7'd0, e.err});
            chk("collisionMask",  {4'd0, collisionMask},  {4'd0, e.cmask});
        end
    end

    task automatic idle_inputs();
        reset = 1'b0; startOfFrame = 1'b0; layerDrawingRequest = 4'b0000;
        cfgValid = 1'b0; cfgOrder = 8'h00; backGroundRGB = 8'h00;
        layerRGB[0] = 8'h11; layerRGB[1] = 8'hE0; layerRGB[2] = 8'h1C; layerRGB[3] = 8'h33;
    endtask

    function automatic logic [7:0] rand_perm();
        int a[4];
        int j, t;
        logic [7:0] o;
        for (int s = 0; s < 4; s++) a[s] = s;
        for (int s = 3; s > 0; s--) begin
            j = int'($urandom_range(s, 0));
            t = a[s]; a[s] = a[j]; a[j] = t;
        end
        for (int s = 0; s < 4; s++) o[2*s +: 2] = 2'(a[s]);
        return o;
    endfunction

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;

        // Basic priority and background.
        layerDrawingRequest = 4'b0110; step();
        layerDrawingRequest = 4'b0000; backGroundRGB = 8'h03; step();

        // Order update mid-frame, takes effect at the next startOfFrame.
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        layerDrawingRequest = 4'b1001;
        cfgValid = 1'b1; cfgOrder = 8'b00_01_10_11; step();
        cfgValid = 1'b0;
        repeat (3) step();
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        repeat (2) step();

        // Duplicate index rejected.
        cfgValid = 1'b1; cfgOrder = 8'b00_00_10_11; step();
        cfgValid = 1'b0; repeat (2) step();

        // Collision between layers 1 and 3 in one frame, then a clean frame.
        layerDrawingRequest = 4'b0001;
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        layerDrawingRequest = 4'b1010; step();
        layerDrawingRequest = 4'b0100; repeat (2) step();
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        repeat (3) step();
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        step();

        // Reset while an update is pending discards it.
        cfgValid = 1'b1; cfgOrder = 8'b01_00_11_10; step();
        cfgValid = 1'b0; step();
        reset = 1'b1; startOfFrame = 1'b1; cfgValid = 1'b1; step();
        reset = 1'b0; startOfFrame = 1'b0; cfgValid = 1'b0; step();
        layerDrawingRequest = 4'b1111;
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0;
        step();

        // Acceptance coinciding with startOfFrame waits for the next frame.
        layerDrawingRequest = 4'b0011;
        startOfFrame = 1'b1; cfgValid = 1'b1; cfgOrder = 8'b00_01_10_11; step();
        startOfFrame = 1'b0; cfgValid = 1'b0; repeat (2) step();
        startOfFrame = 1'b1; step(); startOfFrame = 1'b0; step();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(199, 0) == 0);
            startOfFrame = ($urandom_range(15, 0) == 0);
            layerDrawingRequest = 4'($urandom);
            for (int s = 0; s < 4; s++) layerRGB[s] = 8'($urandom);
            backGroundRGB = 8'($urandom);
            cfgValid = ($urandom_range(3, 0) == 0);
            cfgOrder = $urandom_range(1, 0) ? rand_perm() : 8'($urandom);
            step();
        end

        idle_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
